// File: rtl/cam_array_if.sv
// CAM request/response bundle.
// CAM_MULTI_HIT_EN adds the multi-hit and match-vector outputs.
interface cam_array_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              write_enable_i;
  logic [ADDR_W-1:0] write_address_i;
  logic [WIDTH-1:0]  write_data_i;
  logic              invalidate_i;
  logic              read_enable_i;
  logic [ADDR_W-1:0] read_address_i;
  logic [WIDTH-1:0]  read_data_o;
  logic              read_valid_o;
  logic              search_enable_i;
  logic [WIDTH-1:0]  search_key_i;
  logic              search_done_o;
  logic              search_hit_o;
  logic [ADDR_W-1:0] search_address_o;
  logic [ADDR_W-1:0] free_address_o;
  logic              full_o;
  logic              empty_o;
  logic [ADDR_W:0]   count_o;
`ifdef CAM_MULTI_HIT_EN
  logic              search_multi_hit_o;
  logic [DEPTH-1:0]  search_match_vec_o;
`endif

  modport master (
    output write_enable_i, write_address_i, write_data_i,
    output invalidate_i,
    output read_enable_i, read_address_i,
    input  read_data_o, read_valid_o,
    output search_enable_i, search_key_i,
    input  search_done_o, search_hit_o, search_address_o,
`ifdef CAM_MULTI_HIT_EN
    input  search_multi_hit_o, search_match_vec_o,
`endif
    input  free_address_o, full_o, empty_o, count_o
  );

  modport slave (
    input  write_enable_i, write_address_i, write_data_i,
    input  invalidate_i,
    input  read_enable_i, read_address_i,
    output read_data_o, read_valid_o,
    input  search_enable_i, search_key_i,
    output search_done_o, search_hit_o, search_address_o,
`ifdef CAM_MULTI_HIT_EN
    output search_multi_hit_o, search_match_vec_o,
`endif
    output free_address_o, full_o, empty_o, count_o
  );
endinterface

// File: rtl/cam_array.sv
// Content-addressable memory: indexed write/read/invalidate plus search.
// Define CAM_MULTI_HIT_EN to add multi-hit flag and match-vector outputs.
module cam_array #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic        clk_i,
  input logic        reset_i,
  cam_array_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;

  logic [WIDTH-1:0]  rd_data_q;
  logic              rd_valid_q;
  logic              srch_done_q;
  logic              srch_hit_q;
  logic [ADDR_W-1:0] srch_addr_q;

  logic              wr_ok;
  logic              rd_ok;
  logic              wr_take;
  logic              inv_take;
  logic [DEPTH-1:0]  match;
  logic [ADDR_W-1:0] hit_idx;
  logic [ADDR_W-1:0] free_idx;

  assign wr_ok    = {1'b0, bus.write_address_i} < DEPTH_C;
  assign rd_ok    = {1'b0, bus.read_address_i} < DEPTH_C;
  assign wr_take  = bus.write_enable_i && wr_ok;
  assign inv_take = bus.invalidate_i && wr_ok;

  // Data storage has no reset; only valid bits qualify it.
  always_ff @(posedge clk_i) begin
    if (wr_take)
      data_q[bus.write_address_i] <= bus.write_data_i;
  end

  // Valid bits: invalidate beats a same-address write.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      valid_q <= '0;
    else if (inv_take)
      valid_q[bus.write_address_i] <= 1'b0;
    else if (wr_take)
      valid_q[bus.write_address_i] <= 1'b1;
  end

  // Occupancy change follows the valid-bit transition only.
  always_comb begin
    count_d = count_q;
    if (inv_take && valid_q[bus.write_address_i])
      count_d = count_q - 1'b1;
    else if (!inv_take && wr_take && !valid_q[bus.write_address_i])
      count_d = count_q + 1'b1;
  end

  // Occupancy register.
  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  // Indexed read pipeline; data holds when idle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.read_enable_i && rd_ok &&
                    valid_q[bus.read_address_i];
      if (bus.read_enable_i)
        rd_data_q <= rd_ok ? data_q[bus.read_address_i] : '0;
    end
  end

  // Parallel compare against pre-update state.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++)
      match[i] = valid_q[i] && (data_q[i] == bus.search_key_i);
  end

  // Lowest matching index wins.
  always_comb begin
    hit_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (match[i]) hit_idx = ADDR_W'(i);
  end

  // Lowest free slot; stays 0 when full.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!valid_q[i]) free_idx = ADDR_W'(i);
  end

  // Search result register; result holds between searches.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      srch_done_q <= 1'b0;
      srch_hit_q  <= 1'b0;
      srch_addr_q <= '0;
    end else begin
      srch_done_q <= bus.search_enable_i;
      if (bus.search_enable_i) begin
        srch_hit_q  <= |match;
        srch_addr_q <= hit_idx;
      end
    end
  end

`ifdef CAM_MULTI_HIT_EN
  logic [DEPTH-1:0] match_vec_q;
  logic             multi_q;

  // Full match vector and multi-hit flag, captured per search.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      match_vec_q <= '0;
      multi_q     <= 1'b0;
    end else if (bus.search_enable_i) begin
      match_vec_q <= match;
      multi_q     <= |(match & (match - 1'b1));
    end
  end

  assign bus.search_match_vec_o = match_vec_q;
  assign bus.search_multi_hit_o = multi_q;
`endif

  assign bus.read_data_o      = rd_data_q;
  assign bus.read_valid_o     = rd_valid_q;
  assign bus.search_done_o    = srch_done_q;
  assign bus.search_hit_o     = srch_hit_q;
  assign bus.search_address_o = srch_addr_q;
  assign bus.free_address_o   = free_idx;
  assign bus.count_o          = count_q;
  assign bus.full_o           = count_q == DEPTH_C;
  assign bus.empty_o          = count_q == '0;
endmodule

// File: doc/cam_array.md
Name: cam_array

Overview:
- Parametrised content-addressable memory (CAM).
- Holds DEPTH entries of WIDTH bits, each with a per-entry valid bit.
- Supports indexed write, indexed read, invalidate, and a single-cycle-issue associative search with a registered result.
- Generalises the fixed 32-entry one-hot read/write enable decode into a full storage, search and free-slot tracking block for lookup tables.

Parameters:
- WIDTH, 32, data/key width in bits.
- DEPTH, 32, number of entries; any value >= 2, need not be a power of two.
- ADDR_W, $clog2(DEPTH), entry index width; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- write_enable_i  input  1  write write_data_i to entry write_address_i and set its valid bit.
- write_address_i  input  ADDR_W  write index.
- write_data_i  input  WIDTH  write data.
- invalidate_i  input  1  clear valid bit of entry write_address_i.
- read_enable_i  input  1  indexed read request.
- read_address_i  input  ADDR_W  read index.
- read_data_o  output  WIDTH  registered read data.
- read_valid_o  output  1  read_data_o is for a request one cycle earlier and the entry was valid.
- search_enable_i  input  1  search request.
- search_key_i  input  WIDTH  search key.
- search_done_o  output  1  pulses one cycle after search_enable_i.
- search_hit_o  output  1  at least one valid entry equalled the key.
- search_address_o  output  ADDR_W  lowest matching index; 0 on miss.
- free_address_o  output  ADDR_W  lowest invalid index; 0 when full.
- full_o  output  1  all entries valid.
- empty_o  output  1  no entries valid.
- count_o  output  ADDR_W+1  number of valid entries.

Behaviour:
- Reset: all valid bits are 0.
  - read_data_o, read_valid_o, search_done_o, search_hit_o and search_address_o are 0.
  - count_o is 0, empty_o is 1, full_o is 0, free_address_o is 0.
  - Data storage is not reset.
- Reset during an outstanding read or search: the response pulse is suppressed; the outputs are 0 on the cycle after reset deasserts.
- Write: 1-cycle commit. An entry written at edge N is visible to reads and searches issued in cycle N+1.
- Address out of range (address >= DEPTH): write and invalidate are ignored.
  - A read returns read_valid_o=0 and read_data_o=0.
- write_enable_i and invalidate_i together on the same address: invalidate wins, so the entry ends invalid.
  - Data may still be updated.
- Read: latency 1 cycle.
  - read_valid_o = the registered valid bit of the addressed entry.
  - read_data_o holds its last value when read_enable_i=0; read_valid_o drops to 0.
- Search: latency 1 cycle, one search accepted per cycle with no backpressure.
  - Compare is against the state before any same-cycle write or invalidate.
  - Priority encoder selects the lowest matching index.
  - Invalid entries never match, even if their stale data equals the key.
- Simultaneous search, read and write in one cycle are all legal and independent.
- count_o:
  - increments on a write to an invalid entry;
  - decrements on an invalidate of a valid entry;
  - is unchanged on an overwrite of a valid entry;
  - never wraps past DEPTH or below 0.
- full_o, empty_o and free_address_o are combinational from the registered valid vector and count.
- No internal state machine beyond the registered valid vector, the count, and the read and search pipeline registers.

Optional Feature:
- Macro: CAM_MULTI_HIT_EN.
- Defined:
  - Adds output search_multi_hit_o (1 bit), asserted with search_done_o when two or more valid entries match.
  - Adds output search_match_vec_o (DEPTH bits), the registered one-hot/multi-hot match vector.
  - Both outputs reset to 0.
- Undefined: these ports do not exist and no match vector register is built; search_address_o is still lowest-index priority.

Test Plan:
- Reset, then idle -> count_o=0, empty_o=1, full_o=0, free_address_o=0, search_hit_o=0 after a search for 0x00000000.
- Write 0xDEADBEEF to entry 1, then search 0xDEADBEEF -> search_done_o=1, search_hit_o=1, search_address_o=1 next cycle, count_o=1, free_address_o=0.
- Write 0xA5A5A5A5 to entries 3 and 7, then search -> search_address_o=3.
  - With CAM_MULTI_HIT_EN: search_multi_hit_o=1, search_match_vec_o=32'h00000088.
- Same cycle: write 0x12345678 to entry 2 and search 0x12345678 -> miss. Repeat the search next cycle -> hit at address 2.
- Fill all 32 entries -> full_o=1, count_o=32. Invalidate entry 5 -> full_o=0, count_o=31, free_address_o=5, read of entry 5 gives read_valid_o=0.
- Issue a search on the hit entry, assert reset_i on the following edge -> search_done_o=0, count_o=0, empty_o=1, and all prior keys miss.
